// File: rtl/synth_op_fifo.sv
// Operator-1 tone generator with an output sample FIFO drained to the DAC at a fixed tick.
// Optional build macro SYNTH_OP_AMP_EN enables the amplitude multiplier (sample = w when undefined).
module synth_op_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] synth_ctrl,
    input  logic [7:0] synth_data,
    input  logic       err_clr,
    output logic       fifo_full,
    output logic [7:0] dac_data,
    output logic       dac_strobe,
    output logic       overflow,
    output logic       underrun
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    localparam logic [7:0] CMD_STEP        = 8'h01;
    localparam logic [7:0] CMD_PUSH        = 8'h81;
    localparam logic [7:0] CMD_LOAD_INC_LO = 8'h41;
    localparam logic [7:0] CMD_LOAD_INC_HI = 8'h51;
    localparam logic [7:0] CMD_LOAD_AMP    = 8'h11;
    localparam logic [7:0] CMD_LOAD_WAVE   = 8'h20;

    logic [15:0]   r_phase;
    logic [15:0]   r_inc;
    logic [7:0]    r_amp;
    logic [1:0]    r_wave;
    logic [7:0]    r_sample;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_div;
    logic [7:0]    r_dac_data;
    logic          r_dac_strobe;
    logic          r_overflow;
    logic          r_underrun;

    logic        w_step, w_push, w_ld_inc_lo, w_ld_inc_hi, w_ld_amp, w_ld_wave;
    logic [15:0] w_phase_next;
    logic [7:0]  w_wave;
    logic [7:0]  w_sample_next;
    logic        w_tick, w_empty, w_full;
    logic        w_do_push, w_do_pop;

    function automatic logic [7:0] wave_fn(input logic [15:0] ph, input logic [1:0] wv);
        logic [7:0] v;
        case (wv)
            2'd0:    v = ph[15:8];
            2'd1:    v = ph[15] ? 8'hFF : 8'h00;
            2'd2:    v = ph[15] ? ~{ph[14:8], 1'b0} : {ph[14:8], 1'b0};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Command decode: exact 8-bit match, one strobe per cycle
    always_comb begin
        w_step      = 1'b0;
        w_push      = 1'b0;
        w_ld_inc_lo = 1'b0;
        w_ld_inc_hi = 1'b0;
        w_ld_amp    = 1'b0;
        w_ld_wave   = 1'b0;
        case (synth_ctrl)
            CMD_STEP:        w_step      = 1'b1;
            CMD_PUSH:        w_push      = 1'b1;
            CMD_LOAD_INC_LO: w_ld_inc_lo = 1'b1;
            CMD_LOAD_INC_HI: w_ld_inc_hi = 1'b1;
            CMD_LOAD_AMP:    w_ld_amp    = 1'b1;
            CMD_LOAD_WAVE:   w_ld_wave   = 1'b1;
            default:         w_step      = 1'b0;
        endcase
    end

    // Sample is derived from the post-step phase so it lands on the same edge as the step
    assign w_phase_next = r_phase + r_inc;
    assign w_wave       = wave_fn(w_phase_next, r_wave);

`ifdef SYNTH_OP_AMP_EN
    logic [15:0] w_prod;
    assign w_prod        = w_wave * r_amp;
    assign w_sample_next = w_prod[15:8];
`else
    logic w_amp_unused;
    assign w_amp_unused  = ^r_amp;
    assign w_sample_next = w_wave;
`endif

    assign w_tick    = (r_div == DIV_LAST);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_push = w_push & ~w_full;
    assign w_do_pop  = w_tick & ~w_empty;
    assign fifo_full = w_full;

    // Operator registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= 16'h0000;
            r_inc    <= 16'h0000;
            r_amp    <= 8'hFF;
            r_wave   <= 2'd0;
            r_sample <= 8'h00;
        end else begin
            if (w_step) begin
                r_phase  <= w_phase_next;
                r_sample <= w_sample_next;
            end
            if (w_ld_inc_lo) r_inc[7:0]  <= synth_data;
            if (w_ld_inc_hi) r_inc[15:8] <= synth_data;
            if (w_ld_amp)    r_amp       <= synth_data;
            if (w_ld_wave)   r_wave      <= synth_data[1:0];
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= r_sample;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sample-rate divider and DAC output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div        <= 16'h0000;
            r_dac_data   <= 8'h00;
            r_dac_strobe <= 1'b0;
        end else begin
            r_div        <= w_tick ? 16'h0000 : r_div + 16'h0001;
            r_dac_strobe <= w_tick;
            if (w_do_pop) r_dac_data <= r_mem[r_rd_ptr];
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push & w_full)    r_overflow <= 1'b1;
            else if (err_clr)       r_overflow <= 1'b0;
            if (w_tick & w_empty)   r_underrun <= 1'b1;
            else if (err_clr)       r_underrun <= 1'b0;
        end
    end

    assign dac_data   = r_dac_data;
    assign dac_strobe = r_dac_strobe;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_synth_op_fifo.sv
// Directed self-checking bench for synth_op_fifo (DEPTH 16, DIV 32); expectations follow SYNTH_OP_AMP_EN.
module tb_synth_op_fifo;

    localparam int DEPTH = 16;
    localparam int DIV   = 32;

`ifdef SYNTH_OP_AMP_EN
    localparam logic [7:0] E_SAW1 = 8'h00, E_SAW2 = 8'h01, E_SAW3 = 8'h02;
    localparam logic [7:0] E_SQ1  = 8'h7F;
    localparam logic [7:0] E_TRI1 = 8'h30, E_TRI2 = 8'h60, E_TRI3 = 8'h6F, E_TRI4 = 8'h0F;
`else
    localparam logic [7:0] E_SAW1 = 8'h01, E_SAW2 = 8'h02, E_SAW3 = 8'h03;
    localparam logic [7:0] E_SQ1  = 8'hFF;
    localparam logic [7:0] E_TRI1 = 8'h60, E_TRI2 = 8'hC0, E_TRI3 = 8'hDF, E_TRI4 = 8'h1F;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] synth_ctrl = 8'h00;
    logic [7:0] synth_data = 8'h00;
    logic       err_clr = 1'b0;
    logic       fifo_full;
    logic [7:0] dac_data;
    logic       dac_strobe;
    logic       overflow;
    logic       underrun;

    int n_chk = 0;
    int n_err = 0;

    synth_op_fifo #(.DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .synth_ctrl (synth_ctrl),
        .synth_data (synth_data),
        .err_clr    (err_clr),
        .fifo_full  (fifo_full),
        .dac_data   (dac_data),
        .dac_strobe (dac_strobe),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] c, input logic [7:0] d);
        synth_ctrl = c;
        synth_data = d;
        @(negedge clk);
        synth_ctrl = 8'h00;
        synth_data = 8'h00;
    endtask

    task automatic clr_cyc(input logic [7:0] c);
        err_clr = 1'b1;
        cyc(c, 8'h00);
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 8'h00);
    endtask

    task automatic wait_strobe(input string tag, input logic [7:0] exp_data);
        logic found;
        found = 1'b0;
        for (int i = 0; i < DIV + 4; i++) begin
            @(negedge clk);
            if (dac_strobe) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'd0, found}, 32'd1);
        chk({tag, "_data"}, {24'd0, dac_data}, {24'd0, exp_data});
    endtask

    // Divider starts at 0 on release, so the tick lands exactly DIV edges later
    task automatic first_tick(input string tag);
        idle(DIV - 1);
        chk({tag, "_pre_strobe"}, {31'd0, dac_strobe}, 32'd0);
        idle(1);
        chk({tag, "_strobe"}, {31'd0, dac_strobe}, 32'd1);
        chk({tag, "_underrun"}, {31'd0, underrun}, 32'd1);
        chk({tag, "_data"}, {24'd0, dac_data}, 32'd0);
        idle(1);
        chk({tag, "_pulse_end"}, {31'd0, dac_strobe}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_data", {24'd0, dac_data}, 32'd0);
        chk("rst_strobe", {31'd0, dac_strobe}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_unr", {31'd0, underrun}, 32'd0);
        reset = 1'b0;

        first_tick("tick0");
        clr_cyc(8'h00);
        chk("unr_clr", {31'd0, underrun}, 32'd0);

        // Saw wave, inc 0x0100
        cyc(8'h41, 8'h00);
        cyc(8'h51, 8'h01);
        cyc(8'h20, 8'h00);
        cyc(8'h11, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h01, 8'h00);
            cyc(8'h81, 8'h00);
        end
        wait_strobe("saw0", E_SAW1);
        wait_strobe("saw1", E_SAW2);
        wait_strobe("saw2", E_SAW3);
        chk("saw_no_unr", {31'd0, underrun}, 32'd0);

        // Fill to DEPTH and overflow, all within one tick period
        for (int i = 0; i < DEPTH - 1; i++) cyc(8'h81, 8'h00);
        chk("fill_not_full", {31'd0, fifo_full}, 32'd0);
        cyc(8'h81, 8'h00);
        chk("fill_full", {31'd0, fifo_full}, 32'd1);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
        cyc(8'h81, 8'h00);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_still_full", {31'd0, fifo_full}, 32'd1);
        clr_cyc(8'h00);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        clr_cyc(8'h81);
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        clr_cyc(8'h00);
        chk("ovf_clr2", {31'd0, overflow}, 32'd0);
        idle(DIV - 21);
        chk("pre_tick_full", {31'd0, fifo_full}, 32'd1);
        cyc(8'h81, 8'h00);
        chk("tickpush_strobe", {31'd0, dac_strobe}, 32'd1);
        chk("tickpush_ovf", {31'd0, overflow}, 32'd1);
        chk("tickpush_full", {31'd0, fifo_full}, 32'd0);
        chk("tickpush_data", {24'd0, dac_data}, {24'd0, E_SAW3});
        cyc(8'h81, 8'h00);
        chk("refill_full", {31'd0, fifo_full}, 32'd1);

        // Asynchronous reset between a push and a tick
        cyc(8'h81, 8'h00);
        reset = 1'b1;
        #1;
        chk("arst_full", {31'd0, fifo_full}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_data", {24'd0, dac_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        first_tick("tick1");
        clr_cyc(8'h00);

        // Square, triangle, silent, and ignored codes
        cyc(8'h20, 8'h01);
        cyc(8'h41, 8'h00);
        cyc(8'h51, 8'h80);
        cyc(8'h11, 8'h80);
        cyc(8'h01, 8'h00); cyc(8'h81, 8'h00);
        cyc(8'h01, 8'h00); cyc(8'h81, 8'h00);
        cyc(8'h20, 8'h02);
        cyc(8'h41, 8'h00);
        cyc(8'h51, 8'h30);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h01, 8'h00);
            cyc(8'h81, 8'h00);
        end
        cyc(8'h20, 8'h03);
        cyc(8'h01, 8'h00); cyc(8'h81, 8'h00);
        cyc(8'h20, 8'h02);
        cyc(8'h50, 8'h00);
        cyc(8'h02, 8'h00);
        cyc(8'h81, 8'h00);
        cyc(8'h01, 8'h00); cyc(8'h81, 8'h00);
        wait_strobe("sq0", E_SQ1);
        wait_strobe("sq1", 8'h00);
        wait_strobe("tri0", E_TRI1);
        wait_strobe("tri1", E_TRI2);
        wait_strobe("tri2", E_TRI3);
        wait_strobe("sil0", 8'h00);
        wait_strobe("nostep", 8'h00);
        wait_strobe("tri3", E_TRI4);
        chk("drain_no_unr", {31'd0, underrun}, 32'd0);
        wait_strobe("empty_hold", E_TRI4);
        chk("empty_unr", {31'd0, underrun}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/synth_op_fifo.md
# synth_op_fifo

Operator-1 tone generator and output sample buffer, directly downstream of the synth command arbiter. Decodes the arbiter's `synth_ctrl`/`synth_data` bus into register loads, phase steps and sample pushes. Buffers generated samples in a small FIFO, returns `fifo_full` to the arbiter as its stall input, and drains samples to the DAC at a fixed sample-rate tick.

## Interface
- `DEPTH`, 16, FIFO depth in samples; power of two, ≥ 2.
- `DIV`, 256, clocks per DAC sample tick; ≥ 2, fits in 16 bits.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `synth_ctrl` in 8: command code from the arbiter; 0x00 means idle.
- `synth_data` in 8: data byte, valid when `synth_ctrl` is a load code.
- `err_clr` in 1: synchronous clear of the sticky error flags.
- `fifo_full` out 1: FIFO holds `DEPTH` samples.
- `dac_data` out 8: last sample popped to the DAC.
- `dac_strobe` out 1: one-cycle pulse on each sample tick.
- `overflow` out 1: sticky; set when a push is dropped.
- `underrun` out 1: sticky; set when a tick finds the FIFO empty.

## Operation
- Commands decode on exact 8-bit values and act only in the cycle they are present. Any other code is ignored.
  - 0x01 **STEP**: `phase <= phase + inc`, a 16-bit add that wraps modulo 2^16. `sample` is updated on the same edge from the new phase value.
  - 0x81 **PUSH**: write `sample` into the FIFO.
  - 0x41 **LOAD_INC_LO**: `inc[7:0] <= synth_data`.
  - 0x51 **LOAD_INC_HI**: `inc[15:8] <= synth_data`.
  - 0x11 **LOAD_AMP**: `amp <= synth_data`.
  - 0x20 **LOAD_WAVE**: `wave <= synth_data[1:0]`.
- Waveform `w` is computed from `p = phase[15:8]`:
  - `wave` 0 (saw): `w = p`.
  - `wave` 1 (square): `w = phase[15] ? 0xFF : 0x00`.
  - `wave` 2 (triangle): `w = phase[15] ? ~{phase[14:8],0} : {phase[14:8],0}`.
  - `wave` 3 (silent): `w = 0x00`.
- `sample = (w * amp) >> 8`. The product is 16 bits unsigned; take bits [15:8]. See Configuration for the build without scaling.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of width log2(DEPTH)+1.
  - `fifo_full` is combinational: `count == DEPTH`.
  - A PUSH while `fifo_full` is high is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
- Drain:
  - A divider counts 0..DIV-1; the tick fires on the cycle the count equals DIV-1.
  - On a tick: `dac_strobe` = 1.
  - If the FIFO is non-empty, pop the head into `dac_data`.
  - If the FIFO is empty, `dac_data` holds its value and `underrun` is set.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- Push into an empty FIFO on a tick cycle: the pop sees empty, so `underrun` is set. There is no bypass; the pushed sample stays queued.
- `err_clr` clears both flags. A set event in the same cycle wins.

## Timing
- Reset values:
  - `phase` 0, `inc` 0, `amp` 0xFF, `wave` 0, `sample` 0.
  - FIFO empty, both pointers 0, divider 0.
  - `fifo_full` 0, `dac_data` 0x00, `dac_strobe` 0, `overflow` 0, `underrun` 0.
- Reset asserted mid-operation discards FIFO contents immediately. It does not wait for a clock.
- Register-load latency:
  - The new `inc`/`amp`/`wave` value is visible the cycle after the load.
  - A STEP in the following cycle uses the new value.
- STEP latency: `sample` is valid the cycle after STEP. A PUSH one or more cycles later captures it.
  - The arbiter's step → check → push sequence always satisfies this.
- `fifo_full` reflects a push or pop in the cycle after it occurs. The arbiter's full-check in the cycle before its push is therefore exact.
- `dac_data` and `dac_strobe` update together. The first tick after reset occurs DIV cycles after deassertion.

## Configuration
- `SYNTH_OP_AMP_EN`:
  - Defined: the amplitude multiplier is present and `sample = (w * amp) >> 8`.
  - Undefined: `sample = w`. LOAD_AMP still writes `amp`, but the value has no effect on output, and no multiplier is synthesized.

## Test plan
- Load `inc` = 0x0100, saw, `amp` 0xFF (AMP_EN defined). Then 3× (STEP, PUSH) → FIFO holds 0x00, 0x01, 0x02; the next three ticks give `dac_data` 0x00, 0x01, 0x02, each with one `dac_strobe` pulse.
- Issue DEPTH+1 PUSHes with no tick → `fifo_full` = 1 after the DEPTH-th push; the extra push is dropped and `overflow` = 1; `err_clr` → `overflow` = 0.
- Let a tick occur with an empty FIFO after reset → `underrun` = 1, `dac_data` stays 0x00, `dac_strobe` pulses.
- Square wave, `inc` = 0x8000, `amp` 0x80 → STEP gives `sample` 0x7F; a second STEP gives 0x00 (phase wraps).
- Fill the FIFO to DEPTH, then PUSH on a tick cycle → pop occurs, push dropped, `overflow` = 1, count = DEPTH-1.
- Assert `reset` between a PUSH and a tick → FIFO empty, all outputs at reset values; the first post-reset tick sets `underrun`.
